alu_mul_sequencer: RTL
======================

# alu_mul_sequencer

Multi-cycle 32×32→32 (low word) multiply controller that borrows the shared ALU and drives it through a shift-and-add sequence (add, sll, srl) until the product is complete. It sits beside the EX stage of the pipelined core. While `aluBusy` is high, the upstream operand/control mux gives this block ownership of the ALU inputs. Requests and responses use valid/ready handshakes so the hazard unit can stall the pipeline on `reqReady`/`respValid`.

## Interface
Parameters: none. Width fixed at 32; ALU op codes come from the shared package.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `reqValid` input 1: multiply request present.
- `reqReady` output 1: block can accept a request (high only in IDLE).
- `reqA` input 32: multiplicand.
- `reqB` input 32: multiplier.
- `respValid` output 1: product available.
- `respReady` input 1: consumer takes product.
- `product` output 32: low 32 bits of reqA×reqB. Identical for signed and unsigned operands.
- `aluBusy` output 1: block owns ALU inputs this cycle.
- `aluInputA` output 32: ALU operand A.
- `aluInputB` output 32: ALU operand B.
- `aluControl` output 3: ALU op select.
- `aluOut` input 32: ALU result. Combinational, same cycle.

## Operation
- Registers: `acc`, `mc` (multiplicand), `mp` (multiplier), `state`, `product`, `respValid`.
- **IDLE**
  - `reqReady`=1.
  - On accept (`reqValid`&&`reqReady`): `acc`←0, `mc`←`reqA`, `mp`←`reqB`.
  - Next state: `reqB`==0 → DONE with `product`←0; `reqB[0]` → ADD; else → SHL.
- **ADD**
  - ALU: ctrl=000, A=`acc`, B=`mc`.
  - `acc`←`aluOut`; next SHL.
- **SHL**
  - ALU: ctrl=001, A=`mc`, B=1.
  - `mc`←`aluOut`; next SHR.
- **SHR**
  - ALU: ctrl=101, A=`mp`, B=1.
  - `mp`←`aluOut`.
  - `aluOut`==0 → DONE with `product`←`acc`. Here `acc` already includes this iteration's ADD.
  - Otherwise: `aluOut[0]` → ADD, else → SHL.
- **DONE**
  - `respValid`=1.
  - `product` held stable until `respReady`; on `respReady` → IDLE and `respValid`←0.
- Arithmetic: all sums wrap mod 2^32; overflow is discarded silently. The multiply sequence itself never issues sub, slt, or, or sra.
- `aluBusy`=1 in ADD/SHL/SHR. Elsewhere `aluBusy`=0 and ALU outputs are 0 / ctrl 000.
- `reqValid` outside IDLE is ignored. The requester must hold `reqA`/`reqB` stable only on the accept cycle.
- Reset mid-operation aborts immediately: no response is produced, and the ALU is released on the next cycle.

## Timing
- Reset values:
  - state=IDLE.
  - `reqReady`=1 once out of reset, i.e. `rst_n` sampled high.
  - `respValid`=0, `product`=0, `aluBusy`=0, `aluInputA`=`aluInputB`=0, `aluControl`=000.
- Latency:
  - Let h be the index of the highest set bit of `reqB` and p its popcount.
  - `respValid` rises N=2(h+1)+p edges after the accept edge.
  - `reqB`=0: N=0, so DONE is entered on the accept edge itself.
  - Worst case `reqB`=0xFFFFFFFF: N=96.
- Early termination: the loop exits as soon as `mp` shifts to zero. No iteration counter is needed because `mp` reaches zero in ≤32 shifts.
- Throughput:
  - A `respReady` edge returns the block to IDLE; the next accept can happen on the following edge.
  - There is no back-to-back overlap between a response and the next accept.
- `respReady` high before `respValid`: no effect.
- `respValid`&&`respReady` in the same cycle: handshake completes on that edge.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op localparams ALU_ADD=000, ALU_SLL=001, ALU_SRA=010, ALU_SUB=011, ALU_SLT=100, ALU_SRL=101, ALU_OR=110. These are reused by the decoder and this block.
  - Sequencer state enum: IDLE, ADD, SHL, SHR, DONE.
- Single flat module; no sub-module.
- The ALU is instantiated outside the block. The bench instantiates the existing ALU and ties `aluOut` back.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles → `reqReady`=1 after release, `respValid`=0, `product`=0, `aluBusy`=0.
- **Small operands:** A=3, B=5 → `respValid` 8 edges after accept, `product`=15. ALU ctrl trace: 000,001,101,001,101,000,001,101.
- **Zero and limits:**
  - B=0, A=0xDEADBEEF → `respValid` right after accept, `product`=0.
  - A=1, B=0xFFFFFFFF → N=96, `product`=0xFFFFFFFF.
- **Wrap and signed:**
  - A=0x80000000, B=2 → `product`=0 (wrap).
  - A=-3 (0xFFFFFFFD), B=7 → `product`=0xFFFFFFEB (−21).
- **Handshakes:**
  - Hold `respReady`=0 for 5 cycles → `product` stable, `reqReady`=0, and a `reqValid` pulse is ignored.
  - Then `respReady`=1 → IDLE on the next edge, and a new request is accepted on the edge after.
- **Mid-operation reset:** `rst_n`=0 during SHL of A=7, B=9 → next cycle IDLE with `aluBusy`=0 and no `respValid`. A fresh A=2, B=2 then yields 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes and multiply sequencer states.
// Used by the decoder and by alu_mul_sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHL,
    SHR,
    DONE
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 low-word multiplier that borrows
// the shared ALU while the multiply is in flight.
module alu_mul_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqA,
  input  logic [31:0] reqB,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] product,
  output logic        aluBusy,
  output logic [31:0] aluInputA,
  output logic [31:0] aluInputB,
  output logic [2:0]  aluControl,
  input  logic [31:0] aluOut
);

  seq_state_t  state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] mc, mc_nxt;
  logic [31:0] mp, mp_nxt;
  logic [31:0] prod_nxt;
  logic        rv_nxt;

  // state and datapath registers, reset aborts any multiply
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      product   <= '0;
      respValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      mc        <= mc_nxt;
      mp        <= mp_nxt;
      product   <= prod_nxt;
      respValid <= rv_nxt;
    end
  end

  // next state, datapath updates and ALU drive
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mc_nxt     = mc;
    mp_nxt     = mp;
    prod_nxt   = product;
    rv_nxt     = respValid;
    reqReady   = 1'b0;
    aluBusy    = 1'b0;
    aluInputA  = '0;
    aluInputB  = '0;
    aluControl = ALU_ADD;
    unique case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          acc_nxt = '0;
          mc_nxt  = reqA;
          mp_nxt  = reqB;
          if (reqB == '0) begin
            state_nxt = DONE;
            prod_nxt  = '0;
            rv_nxt    = 1'b1;
          end else if (reqB[0]) begin
            state_nxt = ADD;
          end else begin
            state_nxt = SHL;
          end
        end
      end
      ADD: begin
        aluBusy    = 1'b1;
        aluControl = ALU_ADD;
        aluInputA  = acc;
        aluInputB  = mc;
        acc_nxt    = aluOut;
        state_nxt  = SHL;
      end
      SHL: begin
        aluBusy    = 1'b1;
        aluControl = ALU_SLL;
        aluInputA  = mc;
        aluInputB  = 32'd1;
        mc_nxt     = aluOut;
        state_nxt  = SHR;
      end
      SHR: begin
        aluBusy    = 1'b1;
        aluControl = ALU_SRL;
        aluInputA  = mp;
        aluInputB  = 32'd1;
        mp_nxt     = aluOut;
        if (aluOut == '0) begin
          state_nxt = DONE;
          prod_nxt  = acc;
          rv_nxt    = 1'b1;
        end else if (aluOut[0]) begin
          state_nxt = ADD;
        end else begin
          state_nxt = SHL;
        end
      end
      DONE: begin
        if (respReady) begin
          state_nxt = IDLE;
          rv_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
